// File: rtl/mmp_pkg.sv
// ============================================================================
// mmp_pkg: shared constants and helpers for the MMP multiplier.
// Rev 1.0
// ============================================================================
`default_nettype none

package mmp_pkg;

  localparam int unsigned MMP_N = 8;

  // Bit positions of the datapath signals within the controller's control word.
  localparam int unsigned CW_LOAD_REGS  = 4;
  localparam int unsigned CW_SHIFT_REGS = 5;
  localparam int unsigned CW_ADD_REGS   = 6;
  localparam int unsigned CW_DECR_P     = 7;
  localparam int unsigned CW_READY      = 8;

  typedef enum logic [1:0] {
    COND_Q0   = 2'd2,
    COND_ZERO = 2'd3
  } cond_sel_e;

  function automatic int unsigned mmp_pw(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmp_down_counter.sv
// ============================================================================
// mmp_down_counter: loadable down counter that saturates at zero.
// Rev 1.0
// ============================================================================
`default_nettype none

module mmp_down_counter #(
  parameter int unsigned PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [PW-1:0] load_value,
  input  logic          decr,
  output logic [PW-1:0] count,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (decr && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/mmp_datapath.sv
// ============================================================================
// mmp_datapath: shift-and-add multiplier datapath (B, C, A, Q, P) with
// product capture on the rising edge of the controller's ready flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module mmp_datapath
  import mmp_pkg::*;
#(
  parameter int unsigned N = MMP_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           Load_regs,
  input  logic           Add_regs,
  input  logic           Shift_regs,
  input  logic           Decr_P,
  input  logic           ready,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           Q0,
  output logic           Zero,
  output logic [2*N-1:0] product,
  output logic           product_valid
);

  localparam int unsigned PW = mmp_pw(N);

  logic [N-1:0]  reg_b;
  logic [N-1:0]  reg_a;
  logic [N-1:0]  reg_q;
  logic          reg_c;
  logic          ready_d;
  logic [N:0]    sum;
  logic [PW-1:0] count_p;

  assign sum = {1'b0, reg_a} + {1'b0, reg_b};

  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_b <= '0;
      reg_a <= '0;
      reg_q <= '0;
      reg_c <= 1'b0;
    end else if (Load_regs) begin
      reg_b <= multiplicand;
      reg_q <= multiplier;
      reg_a <= '0;
      reg_c <= 1'b0;
    end else if (Add_regs && Shift_regs) begin
      // Carry-out of the sum lands in A's MSB; the sum LSB moves into Q.
      reg_c <= 1'b0;
      reg_a <= sum[N:1];
      reg_q <= {sum[0], reg_q[N-1:1]};
    end else if (Add_regs) begin
      {reg_c, reg_a} <= sum;
    end else if (Shift_regs) begin
      reg_c <= 1'b0;
      reg_a <= {reg_c, reg_a[N-1:1]};
      reg_q <= {reg_a[0], reg_q[N-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_d       <= 1'b0;
      product       <= '0;
      product_valid <= 1'b0;
    end else begin
      ready_d <= ready;
      if (ready && !ready_d) begin
        product       <= {reg_a, reg_q};
        product_valid <= 1'b1;
      end else begin
        product_valid <= 1'b0;
      end
    end
  end

  mmp_down_counter #(
    .PW(PW)
  ) u_counter_p (
    .clk        (clk),
    .rst        (rst),
    .load       (Load_regs),
    .load_value (PW'(N)),
    .decr       (Decr_P),
    .count      (count_p),
    .zero       (Zero)
  );

  assign Q0 = reg_q[0];

endmodule

`default_nettype wire

// File: tb/tb_mmp_datapath.sv
// ============================================================================
// tb_mmp_datapath: randomized and directed bench for mmp_datapath against an
// arithmetic model of the {C,A,Q} word, counter P and the product capture.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mmp_datapath;

  localparam int N = 8;
  localparam int W = 2 * N + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           Load_regs = 1'b0;
  logic           Add_regs = 1'b0;
  logic           Shift_regs = 1'b0;
  logic           Decr_P = 1'b0;
  logic           ready = 1'b0;
  logic [N-1:0]   multiplicand = '0;
  logic [N-1:0]   multiplier = '0;
  logic           Q0;
  logic           Zero;
  logic [2*N-1:0] product;
  logic           product_valid;

  mmp_datapath #(.N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .Load_regs     (Load_regs),
    .Add_regs      (Add_regs),
    .Shift_regs    (Shift_regs),
    .Decr_P        (Decr_P),
    .ready         (ready),
    .multiplicand  (multiplicand),
    .multiplier    (multiplier),
    .Q0            (Q0),
    .Zero          (Zero),
    .product       (product),
    .product_valid (product_valid)
  );

  always #5 clk = ~clk;

  // Model: the concatenation {C,A,Q} held as one (2N+1)-bit number.
  logic [W-1:0]   m_caq = '0;
  logic [N-1:0]   m_b = '0;
  int             m_p = 0;
  logic           m_rdy_d = 1'b0;
  logic [2*N-1:0] m_prod = '0;
  logic           m_pv = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rn, input logic ld, input logic ad, input logic sh,
                     input logic dc, input logic rd);
    rst = rn; Load_regs = ld; Add_regs = ad; Shift_regs = sh; Decr_P = dc; ready = rd;
    @(posedge clk);
    if (!rn) begin
      m_caq = '0; m_b = '0; m_p = 0; m_rdy_d = 1'b0; m_prod = '0; m_pv = 1'b0;
    end else begin
      if (rd && !m_rdy_d) begin
        m_prod = m_caq[2*N-1:0];
        m_pv   = 1'b1;
      end else begin
        m_pv = 1'b0;
      end
      m_rdy_d = rd;
      if (ld) begin
        m_b   = multiplicand;
        m_caq = W'(multiplier);
        m_p   = N;
      end else begin
        if (ad) m_caq = W'(m_caq[2*N-1:0]) + (W'(m_b) << N);
        if (sh) m_caq = m_caq >> 1;
        if (dc && m_p > 0) m_p = m_p - 1;
      end
    end
    #1;
    check("Q0", 32'(Q0), 32'(m_caq[0]));
    check("Zero", 32'(Zero), 32'(m_p == 0));
    check("product", 32'(product), 32'(m_prod));
    check("product_valid", 32'(product_valid), 32'(m_pv));
    if (product_valid) pulses++;
  endtask

  // Full multiply with the classic microcode: Add-if-Q0 fused with Shift and Decr.
  task automatic run_mult(input logic [N-1:0] a, input logic [N-1:0] b);
    multiplicand = a; multiplier = b;
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(1, 0, Q0, 1, 1, 0);
    check("zero_after_n", 32'(Zero), 32'd1);
    cyc(1, 0, 0, 0, 0, 1);
    check("mul_result", 32'(product), 32'(a) * 32'(b));
    check("mul_valid", 32'(product_valid), 32'd1);
    cyc(1, 0, 0, 0, 0, 0);
    check("mul_valid_drop", 32'(product_valid), 32'd0);
  endtask

  initial begin
    #2;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("rst_q0", 32'(Q0), 32'd0);
    check("rst_zero", 32'(Zero), 32'd1);
    check("rst_product", 32'(product), 32'd0);

    run_mult(8'd13, 8'd11);
    check("13x11", 32'(product), 32'd143);
    run_mult(8'd255, 8'd255);
    check("255x255", 32'(product), 32'hFE01);

    // 0 x 200 with Add and Shift together every cycle.
    multiplicand = 8'd0; multiplier = 8'd200;
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      check("q0_track", 32'(Q0), 32'((8'd200 >> i) & 8'd1));
      cyc(1, 0, 1, 1, 1, 0);
    end
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 0);
    check("p_saturate", 32'(Zero), 32'd1);
    cyc(1, 0, 0, 0, 0, 1);
    check("0x200", 32'(product), 32'd0);
    cyc(1, 0, 0, 0, 0, 0);

    // Hold ready high: exactly one pulse.
    run_mult(8'd7, 8'd9);
    pulses = 0;
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 1);
    check("ready_hold_pulses", 32'(pulses), 32'd1);
    cyc(1, 0, 0, 0, 0, 0);

    // Load coinciding with the ready rising edge captures the previous {A,Q}.
    multiplicand = 8'd3; multiplier = 8'd5;
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(1, 0, Q0, 1, 1, 0);
    multiplicand = 8'd100; multiplier = 8'd100;
    cyc(1, 1, 0, 0, 0, 1);
    check("load_ready_capture", 32'(product), 32'd15);
    cyc(1, 0, 0, 0, 0, 0);

    // Reset mid-multiply at P == 4.
    multiplicand = 8'd201; multiplier = 8'd173;
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, Q0, 1, 1, 0);
    cyc(0, 0, 1, 1, 1, 1);
    check("midrst_zero", 32'(Zero), 32'd1);
    check("midrst_q0", 32'(Q0), 32'd0);
    check("midrst_pv", 32'(product_valid), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    cyc(1, 0, 0, 0, 0, 0);

    for (int k = 0; k < 20; k++) run_mult(N'($urandom), N'($urandom));

    // Random control words, operands and occasional reset.
    for (int k = 0; k < 400; k++) begin
      multiplicand = N'($urandom);
      multiplier   = N'($urandom);
      cyc(($urandom_range(0, 31) != 0), ($urandom_range(0, 9) == 0),
          1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mmp_datapath.md
# mmp_datapath

Shift-and-add multiplier datapath for the MMP multiplier, directly downstream of the microprogrammed controller. It executes the controller's Load/Add/Shift/Decr control word on registers B, C, A, Q and counter P. It returns the branch conditions Q0 and Zero to the controller's condition mux, and captures the 2N-bit product when the controller raises ready.

## Interface
- N, 8, operand width in bits; must be ≥ 2
- PW, $clog2(N+1), width of counter P; derived, not overridden
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- Load_regs  in  1  load operands and initialise A, C, P
- Add_regs  in  1  {C,A} <= A + B
- Shift_regs  in  1  logical right shift of {C,A,Q}
- Decr_P  in  1  P <= P − 1
- ready  in  1  controller done flag; its rising edge captures the product
- multiplicand  in  N  operand B source, sampled only on Load_regs
- multiplier  in  N  operand Q source, sampled only on Load_regs
- Q0  out  1  Q[0], combinational from register
- Zero  out  1  (P == 0), combinational from register
- product  out  2N  registered {A,Q} captured at the ready rising edge
- product_valid  out  1  one-cycle pulse when product updates

## Operation
- Registers: B[N], A[N], Q[N], C[1], P[PW], ready_d[1], product[2N], product_valid.
- Reset (rst=0 at an edge) clears all registers to 0. After reset: Q0=0, Zero=1, product=0, product_valid=0.
- Control priority per cycle:
  - Load_regs overrides Add, Shift and Decr.
  - Load: B<=multiplicand, Q<=multiplier, A<=0, C<=0, P<=N.
- Add only: {C,A} <= A + B as an (N+1)-bit sum. Q is unchanged.
- Shift only: {C,A,Q} <= {1'b0, C, A, Q[N-1:1]}. C becomes 0.
- Add and Shift together: the add result feeds the shift in one cycle, {C,A,Q} <= {1'b0, sum[N:0], Q[N-1:1]}, where sum = A + B.
- Decr_P is independent of Add/Shift and may coincide with either.
  - P saturates at 0; Decr_P with P == 0 holds P = 0.
- No control asserted: all datapath registers hold.
- Product capture: ready_d <= ready every cycle.
  - When ready & ~ready_d: product <= {A,Q} as seen before this edge, and product_valid <= 1.
  - Otherwise product_valid <= 0.
  - Holding ready high gives exactly one pulse; a new pulse needs ready to drop and re-rise.
- Capture reads the pre-edge {A,Q}, so a Load in the same cycle as a ready rising edge still captures the previous result.
- B is never modified except by Load. Changing the multiplicand/multiplier inputs between Loads has no effect.

## Timing
- All state updates occur on the rising clk edge.
- Q0 and Zero are purely combinational from Q[0] and P, with no extra register stage. The controller's mux evaluates them in the same cycle they become valid after an edge.
- Control word to register effect: 1 cycle.
- ready rising edge to product/product_valid: 1 cycle. product_valid stays high for exactly 1 cycle.
- Reset mid-operation clears everything on the next edge. No partial product is captured.
- An operation from Load to P==0 takes N iterations; cycle count depends on the controller microcode, not on this block.

## Structure
- Shared package mmp_pkg:
  - default N
  - PW function
  - control-word bit positions (Load_regs bit 4, Shift_regs bit 5, Add_regs bit 6, Decr_P bit 7, ready bit 8)
  - condition-select codes (Q0 = 2, Zero = 3)
- One sub-module, mmp_down_counter #(PW): synchronous active-low reset, load value, saturating decrement, zero flag output. It implements P and Zero.
- The A/Q/C shift-add logic stays in mmp_datapath.

## Test plan
- Load 13 × 11 (N=8); run 8 iterations of Add-if-Q0 plus Shift with Decr; pulse ready -> product = 143, product_valid high for 1 cycle, Zero = 1.
- Load 255 × 255 -> carry through C exercised, product = 65025 (0xFE01).
- Load 0 × 200 with Add and Shift asserted together every cycle for 8 cycles -> product = 0, Q0 tracks the shifted multiplier bits.
- After P reaches 0, assert Decr_P for 3 more cycles -> P stays 0 and Zero stays 1.
- Hold ready high for 5 cycles -> exactly one product_valid pulse. A Load coinciding with the ready rising edge -> previous {A,Q} captured.
- Drive rst=0 mid-multiply (P=4) -> next cycle all registers 0, Zero=1, Q0=0, no product_valid.
